accel_mem_arbiter: RTL and testbench
====================================

# accel_mem_arbiter

Shares one external memory read channel and one write channel among `N_REQ` accelerator wrappers. Each wrapper uses the codebase's enable/ready/finish memory handshake. Read and write channels are arbitrated independently with round-robin priority. A grant is locked for a requester's whole burst, from `*_enable` rise to `*_enable` fall. The block sits between the accelerator wrappers and the host memory shim, so several kernels can run concurrently.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `ADDR_W`, 64, address/size width
- `DATA_W`, 32, data word width
- `clk` in 1: single clock, all logic rising-edge
- `reset` in 1: reset is asynchronous and active-low
- `req_read_enable` in N_REQ: per-requester read burst request
- `req_read_addr` in N_REQ*ADDR_W: packed, requester i at [i*ADDR_W +: ADDR_W]
- `req_read_size` in N_REQ*ADDR_W: packed read size
- `req_finish_read` in N_REQ: per-word finish pulse
- `req_read_ready` out N_REQ: per-requester data-valid
- `req_read_data` out DATA_W: broadcast copy of `mem_read_data`
- `req_write_enable`, `req_write_addr`, `req_write_size`, `req_write_data` (N_REQ*DATA_W), `req_finish_write`: write counterparts of the read inputs
- `req_write_ready` out N_REQ
- `mem_read_enable`, `mem_finish_read` out 1
- `mem_read_addr`, `mem_read_size` out ADDR_W
- `mem_read_ready` in 64: ready when value == 1
- `mem_read_data` in DATA_W
- `mem_write_enable`, `mem_finish_write` out 1
- `mem_write_addr`, `mem_write_size` out ADDR_W
- `mem_write_data` out DATA_W
- `mem_write_ready` in 64: ready when value == 1
- `rd_grant`, `wr_grant` out N_REQ: one-hot registered grant (0 = none)
- `rd_beats`, `wr_beats` out 32: count of completed beats; wraps at 2^32

## Operation
- The read and write channels are identical and independent. The same requester may hold both at once.
- Per-channel FSM:
  - IDLE: if any enable is high, pick the first high enable at or after `ptr` (cyclic), load the one-hot grant, go to BUSY.
  - BUSY: grant is held. When the granted requester's enable is low, clear the grant, set `ptr` = granted index + 1 (mod N_REQ), go to IDLE.
  - No other transitions exist.
- Memory-side outputs are combinational muxes of the granted requester's inputs. With no grant, all memory outputs are 0.
- Ready routing:
  - `req_*_ready[i]` = (`mem_*_ready` == 1) & grant[i]. Non-granted requesters always see 0 and simply wait.
  - `req_read_data` is broadcast unconditionally.
- Beat counting: a beat is counted on each cycle where a grant is held, `mem_*_ready` == 1, and the granted `req_finish_*` == 1.
- Any `mem_*_ready` seen while no grant is held is ignored: no routing, no count.
- Reset values (all asynchronous):
  - state IDLE, grants 0, `ptr` 0, beat counters 0.
  - Consequently every `mem_*` output and every `req_*_ready` is 0.
- Reset asserted mid-burst: grants drop immediately and memory enables go low. The memory shim is responsible for abandoning the transfer.

## Timing
- Arbitration latency: enable rises in cycle t, grant and `mem_*_enable` are high in t+1.
- Release: enable falls in cycle t, grant clears at the t+1 edge. The next grant is visible at t+2 at the earliest, giving one idle cycle between bursts.
- Address, data and finish are pass-through with zero-cycle added latency while granted.
- Ready is pass-through: 0 cycles.
- Simultaneous requests after reset are granted in order 0,1,2,3, then rotate.
- A requester that holds its enable high indefinitely starves the others on that channel. This is by design: no timeout.

## Structure
- Shared package `accel_mem_pkg`:
  - channel state encodings (`CH_IDLE`, `CH_BUSY`)
  - default `N_REQ`, `ADDR_W`, `DATA_W`
  - `READY_ON` = 64'd1
- One sub-module, `rr_grant_fsm`: one-hot round-robin pick, pointer, IDLE/BUSY FSM and beat counter. It is instantiated twice, once per channel.
- The top level contains only the muxes and ready gating.

## Test plan
- Reset, then req 0 reads 3 words with addresses 0x100, 0x104, 0x108, ready pulsed per word -> `rd_grant`=0001 from the cycle after enable. `mem_read_addr` tracks each address. `req_read_ready[0]` mirrors ready. `rd_beats`=3.
- Reqs 0..3 all raise read enable together, each 1-word burst -> grant order 0001, 0010, 0100, 1000, one idle cycle between grants. Non-granted readies stay 0.
- Req 2 holds the read channel while req 1 runs a 2-word write -> both grants are active concurrently. Memory write signals carry req 1 values. `wr_beats`=2 and `rd_beats` is unaffected.
- `mem_read_ready`=1 asserted with no grant, and `mem_read_ready`=2 while granted -> no `req_read_ready` bit rises and the counter is unchanged.
- Reset asserted mid-burst (grant=0100, `mem_read_enable`=1) -> grants and `mem_read_enable` go to 0 in the same cycle, without waiting for a clock edge. After release, simultaneous requests 2 and 3 grant 2 first (ptr back to 0).

Source files
------------

// File: rtl/accel_mem_arbiter_pkg.sv
// Shared types and defaults for the accelerator memory arbiter.
// Channel FSM encoding, default widths and the memory-ready token.
package accel_mem_pkg;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_BUSY = 1'b1
    } ch_state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 32;

    // The memory shim signals ready with a 64-bit word; only the exact value 1 means ready.
    localparam logic [63:0] READY_ON = 64'd1;

endpackage

// File: rtl/accel_mem_arbiter_if.sv
// Requester-side and memory-side buses of the arbiter.
// The slave modport is the arbiter's view; master is the surrounding environment.
interface accel_mem_arbiter_if #(
    parameter int N_REQ  = accel_mem_pkg::DEF_N_REQ,
    parameter int ADDR_W = accel_mem_pkg::DEF_ADDR_W,
    parameter int DATA_W = accel_mem_pkg::DEF_DATA_W
);
    logic [N_REQ-1:0]        req_read_enable;
    logic [N_REQ*ADDR_W-1:0] req_read_addr;
    logic [N_REQ*ADDR_W-1:0] req_read_size;
    logic [N_REQ-1:0]        req_finish_read;
    logic [N_REQ-1:0]        req_read_ready;
    logic [DATA_W-1:0]       req_read_data;

    logic [N_REQ-1:0]        req_write_enable;
    logic [N_REQ*ADDR_W-1:0] req_write_addr;
    logic [N_REQ*ADDR_W-1:0] req_write_size;
    logic [N_REQ*DATA_W-1:0] req_write_data;
    logic [N_REQ-1:0]        req_finish_write;
    logic [N_REQ-1:0]        req_write_ready;

    logic                    mem_read_enable;
    logic                    mem_finish_read;
    logic [ADDR_W-1:0]       mem_read_addr;
    logic [ADDR_W-1:0]       mem_read_size;
    logic [63:0]             mem_read_ready;
    logic [DATA_W-1:0]       mem_read_data;

    logic                    mem_write_enable;
    logic                    mem_finish_write;
    logic [ADDR_W-1:0]       mem_write_addr;
    logic [ADDR_W-1:0]       mem_write_size;
    logic [DATA_W-1:0]       mem_write_data;
    logic [63:0]             mem_write_ready;

    modport slave (
        input  req_read_enable, req_read_addr, req_read_size, req_finish_read,
        input  req_write_enable, req_write_addr, req_write_size, req_write_data, req_finish_write,
        input  mem_read_ready, mem_read_data, mem_write_ready,
        output req_read_ready, req_read_data, req_write_ready,
        output mem_read_enable, mem_finish_read, mem_read_addr, mem_read_size,
        output mem_write_enable, mem_finish_write, mem_write_addr, mem_write_size, mem_write_data
    );

    modport master (
        output req_read_enable, req_read_addr, req_read_size, req_finish_read,
        output req_write_enable, req_write_addr, req_write_size, req_write_data, req_finish_write,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input  req_read_ready, req_read_data, req_write_ready,
        input  mem_read_enable, mem_finish_read, mem_read_addr, mem_read_size,
        input  mem_write_enable, mem_finish_write, mem_write_addr, mem_write_size, mem_write_data
    );

endinterface

// File: rtl/accel_mem_arbiter_rr_grant_fsm.sv
// Round-robin grant FSM for one memory channel: picks a requester, locks the
// grant for the whole burst, and counts completed beats.
module rr_grant_fsm
    import accel_mem_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] i_enable,
    input  logic [N_REQ-1:0] i_finish,
    input  logic             i_ready,
    output logic [N_REQ-1:0] o_grant,
    output logic [31:0]      o_beats
);
    localparam int IDX_W = $clog2(N_REQ);
    typedef logic [IDX_W-1:0] idx_t;

    ch_state_t        r_state;
    idx_t             r_ptr;
    idx_t             r_idx;
    logic [N_REQ-1:0] r_grant;
    logic [31:0]      r_beats;

    idx_t             w_pick_idx;
    idx_t             w_cand;
    logic             w_pick_valid;
    logic             w_beat;

    // Scan from the farthest candidate back to ptr so the nearest one at or after ptr wins.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick_idx   = '0;
        w_cand       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_cand = idx_t'((int'(r_ptr) + k) % N_REQ);
            if (i_enable[w_cand]) begin
                w_pick_valid = 1'b1;
                w_pick_idx   = w_cand;
            end
        end
    end

    assign w_beat = (r_state == CH_BUSY) & i_ready & (|(i_finish & r_grant));

    // NOTE: the asynchronous reset clears the registered grant at once, which silences every
    // memory-side mux without waiting for a clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= CH_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_beats <= '0;
        end else begin
            if (w_beat) begin
                r_beats <= r_beats + 32'd1;
            end
            case (r_state)
                CH_IDLE: begin
                    if (w_pick_valid) begin
                        r_grant <= {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
                        r_idx   <= w_pick_idx;
                        r_state <= CH_BUSY;
                    end
                end
                CH_BUSY: begin
                    if (!i_enable[r_idx]) begin
                        r_grant <= '0;
                        r_ptr   <= (r_idx == idx_t'(N_REQ - 1)) ? '0 : r_idx + idx_t'(1);
                        r_state <= CH_IDLE;
                    end
                end
                default: r_state <= CH_IDLE;
            endcase
        end
    end

    assign o_grant = r_grant;
    assign o_beats = r_beats;

endmodule

// File: rtl/accel_mem_arbiter.sv
// Shares one memory read channel and one write channel among N_REQ accelerator
// wrappers; each channel has its own round-robin grant FSM.
module accel_mem_arbiter
    import accel_mem_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                clk,
    input  logic                reset,
    accel_mem_arbiter_if.slave  bus,
    output logic [N_REQ-1:0]    rd_grant,
    output logic [N_REQ-1:0]    wr_grant,
    output logic [31:0]         rd_beats,
    output logic [31:0]         wr_beats
);
    logic              w_rd_ready_on;
    logic              w_wr_ready_on;
    logic              w_rd_en;
    logic              w_rd_fin;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_rd_size;
    logic              w_wr_en;
    logic              w_wr_fin;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W-1:0] w_wr_size;
    logic [DATA_W-1:0] w_wr_data;

    assign w_rd_ready_on = (bus.mem_read_ready == READY_ON);
    assign w_wr_ready_on = (bus.mem_write_ready == READY_ON);

    rr_grant_fsm #(.N_REQ(N_REQ)) u_rd_fsm (
        .clk      (clk),
        .reset    (reset),
        .i_enable (bus.req_read_enable),
        .i_finish (bus.req_finish_read),
        .i_ready  (w_rd_ready_on),
        .o_grant  (rd_grant),
        .o_beats  (rd_beats)
    );

    rr_grant_fsm #(.N_REQ(N_REQ)) u_wr_fsm (
        .clk      (clk),
        .reset    (reset),
        .i_enable (bus.req_write_enable),
        .i_finish (bus.req_finish_write),
        .i_ready  (w_wr_ready_on),
        .o_grant  (wr_grant),
        .o_beats  (wr_beats)
    );

    // Grants are one-hot, so selecting on each bit forms a plain mux that yields 0 with no grant.
    always_comb begin
        w_rd_en   = 1'b0;
        w_rd_fin  = 1'b0;
        w_rd_addr = '0;
        w_rd_size = '0;
        w_wr_en   = 1'b0;
        w_wr_fin  = 1'b0;
        w_wr_addr = '0;
        w_wr_size = '0;
        w_wr_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (rd_grant[i]) begin
                w_rd_en   = bus.req_read_enable[i];
                w_rd_fin  = bus.req_finish_read[i];
                w_rd_addr = bus.req_read_addr[i*ADDR_W +: ADDR_W];
                w_rd_size = bus.req_read_size[i*ADDR_W +: ADDR_W];
            end
            if (wr_grant[i]) begin
                w_wr_en   = bus.req_write_enable[i];
                w_wr_fin  = bus.req_finish_write[i];
                w_wr_addr = bus.req_write_addr[i*ADDR_W +: ADDR_W];
                w_wr_size = bus.req_write_size[i*ADDR_W +: ADDR_W];
                w_wr_data = bus.req_write_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign bus.mem_read_enable  = w_rd_en;
    assign bus.mem_finish_read  = w_rd_fin;
    assign bus.mem_read_addr    = w_rd_addr;
    assign bus.mem_read_size    = w_rd_size;
    assign bus.mem_write_enable = w_wr_en;
    assign bus.mem_finish_write = w_wr_fin;
    assign bus.mem_write_addr   = w_wr_addr;
    assign bus.mem_write_size   = w_wr_size;
    assign bus.mem_write_data   = w_wr_data;

    assign bus.req_read_ready   = {N_REQ{w_rd_ready_on}} & rd_grant;
    assign bus.req_write_ready  = {N_REQ{w_wr_ready_on}} & wr_grant;
    assign bus.req_read_data    = bus.mem_read_data;

endmodule

// File: tb/tb_accel_mem_arbiter.sv
// Bench for accel_mem_arbiter: directed scenarios, then random bursts checked
// through a per-cycle scoreboard fed by a transaction-level arbitration model.
module tb_accel_mem_arbiter;
    import accel_mem_pkg::*;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int N_RAND_CYCLES = 1500;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  rd_grant;
    logic [N-1:0]  wr_grant;
    logic [31:0]   rd_beats;
    logic [31:0]   wr_beats;

    accel_mem_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    accel_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .rd_grant (rd_grant),
        .wr_grant (wr_grant),
        .rd_beats (rd_beats),
        .wr_beats (wr_beats)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic [N-1:0]  rd_grant;
        logic [N-1:0]  wr_grant;
        logic [N-1:0]  rd_ready;
        logic [N-1:0]  wr_ready;
        logic          rd_en;
        logic          rd_fin;
        logic          wr_en;
        logic          wr_fin;
        logic [AW-1:0] rd_addr;
        logic [AW-1:0] rd_size;
        logic [AW-1:0] wr_addr;
        logic [AW-1:0] wr_size;
        logic [DW-1:0] wr_data;
        logic [DW-1:0] rd_data;
        logic [31:0]   rd_beats;
        logic [31:0]   wr_beats;
    } obs_t;

    obs_t exp_q[$];
    logic sb_on = 1'b0;
    obs_t mon_exp;
    obs_t mon_act;
    int   sb_cycle = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req_read_enable  = '0;
        bus.req_read_addr    = '0;
        bus.req_read_size    = '0;
        bus.req_finish_read  = '0;
        bus.req_write_enable = '0;
        bus.req_write_addr   = '0;
        bus.req_write_size   = '0;
        bus.req_write_data   = '0;
        bus.req_finish_write = '0;
        bus.mem_read_ready   = '0;
        bus.mem_read_data    = '0;
        bus.mem_write_ready  = '0;
    endtask

    task automatic reset_dut();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Arbitration rules at one clock edge, on plain integers: -1 means no owner.
    task automatic model_step(input logic [N-1:0] en, input logic [N-1:0] fin, input logic [63:0] rdy,
                              inout int owner, inout int ptr, inout logic [31:0] cnt);
        if (owner >= 0) begin
            if (rdy == 64'd1 && fin[owner]) cnt = cnt + 32'd1;
            if (!en[owner]) begin
                ptr   = (owner + 1) % N;
                owner = -1;
            end
        end else begin
            for (int k = 0; k < N; k++)
                if (owner < 0 && en[(ptr + k) % N]) owner = (ptr + k) % N;
        end
    endtask

    function automatic logic [63:0] rand_ready();
        case ($urandom_range(0, 4))
            0:       return 64'd0;
            1, 2:    return 64'd1;
            3:       return 64'd2;
            default: return 64'h1_0000_0001;
        endcase
    endfunction

    function automatic logic [N-1:0] onehot(input int idx);
        return (idx >= 0) ? (N'(1) << idx) : '0;
    endfunction

    always @(negedge clk) begin
        if (sb_on && exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act.rd_grant = rd_grant;
            mon_act.wr_grant = wr_grant;
            mon_act.rd_ready = bus.req_read_ready;
            mon_act.wr_ready = bus.req_write_ready;
            mon_act.rd_en    = bus.mem_read_enable;
            mon_act.rd_fin   = bus.mem_finish_read;
            mon_act.wr_en    = bus.mem_write_enable;
            mon_act.wr_fin   = bus.mem_finish_write;
            mon_act.rd_addr  = bus.mem_read_addr;
            mon_act.rd_size  = bus.mem_read_size;
            mon_act.wr_addr  = bus.mem_write_addr;
            mon_act.wr_size  = bus.mem_write_size;
            mon_act.wr_data  = bus.mem_write_data;
            mon_act.rd_data  = bus.req_read_data;
            mon_act.rd_beats = rd_beats;
            mon_act.wr_beats = wr_beats;
            n_vec++;
            sb_cycle++;
            if (mon_act !== mon_exp) begin
                n_err++;
                $display("FAIL sb_cycle_%0d: got rg=%b wg=%b rr=%b wr=%b ra=%h wa=%h wd=%h rb=%0d wb=%0d expected rg=%b wg=%b rr=%b wr=%b ra=%h wa=%h wd=%h rb=%0d wb=%0d",
                         sb_cycle, mon_act.rd_grant, mon_act.wr_grant, mon_act.rd_ready, mon_act.wr_ready,
                         mon_act.rd_addr, mon_act.wr_addr, mon_act.wr_data, mon_act.rd_beats, mon_act.wr_beats,
                         mon_exp.rd_grant, mon_exp.wr_grant, mon_exp.rd_ready, mon_exp.wr_ready,
                         mon_exp.rd_addr, mon_exp.wr_addr, mon_exp.wr_data, mon_exp.rd_beats, mon_exp.wr_beats);
            end
        end
    end

    initial begin
        logic [DW-1:0] d;
        int            rd_owner, rd_ptr, wr_owner, wr_ptr;
        logic [31:0]   rd_cnt, wr_cnt;
        int            rd_left[N];
        int            wr_left[N];
        logic [AW-1:0] rd_next[N];
        logic [AW-1:0] wr_next[N];
        obs_t          e;

        // Reset state, with a stray ready on both channels.
        clear_inputs();
        bus.mem_read_ready  = 64'd1;
        bus.mem_write_ready = 64'd1;
        #1;
        check("rst_rd_grant", 64'(rd_grant), 0);
        check("rst_wr_grant", 64'(wr_grant), 0);
        check("rst_rd_beats", 64'(rd_beats), 0);
        check("rst_wr_beats", 64'(wr_beats), 0);
        check("rst_mem_rd_en", 64'(bus.mem_read_enable), 0);
        check("rst_mem_wr_en", 64'(bus.mem_write_enable), 0);
        check("rst_rd_ready", 64'(bus.req_read_ready), 0);
        check("rst_rd_addr", bus.mem_read_addr, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        bus.mem_read_ready  = '0;
        bus.mem_write_ready = '0;

        // Requester 0 reads three words.
        tick();
        bus.req_read_enable[0] = 1'b1;
        bus.req_read_addr[0 +: AW] = 64'h100;
        bus.req_read_size[0 +: AW] = 64'd3;
        #1;
        check("t1_grant_same_cycle", 64'(rd_grant), 0);
        tick();
        check("t1_grant", 64'(rd_grant), 64'b0001);
        check("t1_mem_rd_en", 64'(bus.mem_read_enable), 1);
        check("t1_mem_rd_size", bus.mem_read_size, 3);
        for (int w = 0; w < 3; w++) begin
            tick();
            d = $urandom;
            bus.req_read_addr[0 +: AW] = 64'h100 + 64'(4 * w);
            bus.mem_read_ready = 64'd1;
            bus.mem_read_data  = d;
            bus.req_finish_read[0] = 1'b1;
            #1;
            check("t1_mem_rd_addr", bus.mem_read_addr, 64'h100 + 64'(4 * w));
            check("t1_rd_ready", 64'(bus.req_read_ready), 64'b0001);
            check("t1_rd_data", 64'(bus.req_read_data), 64'(d));
            check("t1_mem_fin", 64'(bus.mem_finish_read), 1);
            tick();
            bus.mem_read_ready = '0;
            bus.req_finish_read[0] = 1'b0;
            #1;
            check("t1_rd_ready_gap", 64'(bus.req_read_ready), 0);
        end
        tick();
        bus.req_read_enable[0] = 1'b0;
        #1;
        check("t1_rd_beats", 64'(rd_beats), 3);
        check("t1_grant_held_on_fall", 64'(rd_grant), 64'b0001);
        tick();
        check("t1_grant_cleared", 64'(rd_grant), 0);
        check("t1_mem_rd_en_off", 64'(bus.mem_read_enable), 0);

        // All four request together, one word each: rotating order with idle gaps.
        reset_dut();
        tick();
        for (int i = 0; i < N; i++) bus.req_read_addr[i*AW +: AW] = 64'h1000 * 64'(i);
        bus.req_read_enable = '1;
        for (int k = 0; k < N; k++) begin
            tick();
            check("t2_grant_order", 64'(rd_grant), 64'(onehot(k)));
            bus.mem_read_ready = 64'd1;
            bus.req_finish_read[k] = 1'b1;
            #1;
            check("t2_ready_only_granted", 64'(bus.req_read_ready), 64'(onehot(k)));
            check("t2_mem_rd_addr", bus.mem_read_addr, 64'h1000 * 64'(k));
            tick();
            bus.req_read_enable[k] = 1'b0;
            bus.req_finish_read[k] = 1'b0;
            bus.mem_read_ready = '0;
            tick();
            check("t2_idle_gap", 64'(rd_grant), 0);
        end
        check("t2_rd_beats", 64'(rd_beats), 4);

        // Req 2 holds read while req 1 runs a two-word write.
        tick();
        bus.req_read_enable[2] = 1'b1;
        bus.req_read_addr[2*AW +: AW] = 64'h2000;
        bus.req_write_enable[1] = 1'b1;
        bus.req_write_addr[1*AW +: AW] = 64'h300;
        bus.req_write_size[1*AW +: AW] = 64'd2;
        bus.req_write_data[1*DW +: DW] = 32'hA5A5_0001;
        tick();
        check("t3_rd_grant", 64'(rd_grant), 64'b0100);
        check("t3_wr_grant", 64'(wr_grant), 64'b0010);
        check("t3_mem_wr_en", 64'(bus.mem_write_enable), 1);
        check("t3_mem_wr_size", bus.mem_write_size, 2);
        for (int w = 0; w < 2; w++) begin
            tick();
            bus.req_write_addr[1*AW +: AW] = 64'h300 + 64'(4 * w);
            bus.req_write_data[1*DW +: DW] = 32'hA5A5_0001 + 32'(w);
            bus.mem_write_ready = 64'd1;
            bus.req_finish_write[1] = 1'b1;
            #1;
            check("t3_wr_ready", 64'(bus.req_write_ready), 64'b0010);
            check("t3_mem_wr_addr", bus.mem_write_addr, 64'h300 + 64'(4 * w));
            check("t3_mem_wr_data", 64'(bus.mem_write_data), 64'(32'hA5A5_0001 + 32'(w)));
            check("t3_mem_wr_fin", 64'(bus.mem_finish_write), 1);
        end
        tick();
        bus.mem_write_ready = '0;
        bus.req_finish_write[1] = 1'b0;
        bus.req_write_enable[1] = 1'b0;
        tick();
        check("t3_wr_beats", 64'(wr_beats), 2);
        check("t3_rd_beats_same", 64'(rd_beats), 4);
        check("t3_wr_grant_clr", 64'(wr_grant), 0);
        check("t3_rd_still_held", 64'(rd_grant), 64'b0100);

        // Ready values other than exactly 1 while granted are not ready.
        bus.mem_read_ready = 64'd2;
        bus.req_finish_read[2] = 1'b1;
        #1;
        check("t4_ready_two", 64'(bus.req_read_ready), 0);
        tick();
        bus.mem_read_ready = 64'h1_0000_0001;
        #1;
        check("t4_ready_upper", 64'(bus.req_read_ready), 0);
        tick();
        bus.mem_read_ready = '0;
        bus.req_finish_read[2] = 1'b0;
        bus.req_read_enable[2] = 1'b0;
        #1;
        check("t4_beats_unchanged", 64'(rd_beats), 4);
        tick();
        check("t4_rd_released", 64'(rd_grant), 0);
        // Ready with no grant is ignored.
        bus.mem_read_ready = 64'd1;
        bus.req_finish_read[2] = 1'b1;
        #1;
        check("t4_nogrant_ready", 64'(bus.req_read_ready), 0);
        tick();
        check("t4_nogrant_beats", 64'(rd_beats), 4);
        bus.mem_read_ready = '0;
        bus.req_finish_read[2] = 1'b0;

        // Reset mid-burst, then pointer must be back at 0.
        tick();
        bus.req_read_enable[2] = 1'b1;
        tick();
        check("t5_grant_before_rst", 64'(rd_grant), 64'b0100);
        check("t5_mem_en_before_rst", 64'(bus.mem_read_enable), 1);
        #1;
        reset = 1'b0;
        #1;
        check("t5_async_grant_clr", 64'(rd_grant), 0);
        check("t5_async_mem_en_clr", 64'(bus.mem_read_enable), 0);
        clear_inputs();
        tick();
        tick();
        reset = 1'b1;
        bus.req_read_enable[2] = 1'b1;
        bus.req_read_enable[3] = 1'b1;
        tick();
        check("t5_ptr_reset_pick", 64'(rd_grant), 64'b0100);

        // Random bursts against the arbitration model.
        reset_dut();
        rd_owner = -1; rd_ptr = 0; rd_cnt = '0;
        wr_owner = -1; wr_ptr = 0; wr_cnt = '0;
        for (int i = 0; i < N; i++) begin
            rd_left[i] = 0; wr_left[i] = 0;
            rd_next[i] = '0; wr_next[i] = '0;
        end
        sb_on = 1'b1;
        for (int c = 0; c < N_RAND_CYCLES; c++) begin
            @(posedge clk);
            model_step(bus.req_read_enable, bus.req_finish_read, bus.mem_read_ready, rd_owner, rd_ptr, rd_cnt);
            model_step(bus.req_write_enable, bus.req_finish_write, bus.mem_write_ready, wr_owner, wr_ptr, wr_cnt);
            for (int i = 0; i < N; i++) begin
                if (bus.req_finish_read[i])  begin rd_left[i]--; rd_next[i] += 64'd4; end
                if (bus.req_finish_write[i]) begin wr_left[i]--; wr_next[i] += 64'd4; end
            end
            #1;
            bus.mem_read_ready  = rand_ready();
            bus.mem_write_ready = rand_ready();
            bus.mem_read_data   = $urandom;
            for (int i = 0; i < N; i++) begin
                if (bus.req_read_enable[i] && rd_left[i] == 0) begin
                    bus.req_read_enable[i] = 1'b0;
                end else if (!bus.req_read_enable[i] && $urandom_range(0, 3) == 0) begin
                    bus.req_read_enable[i] = 1'b1;
                    rd_left[i] = $urandom_range(1, 4);
                    rd_next[i] = {$urandom, $urandom};
                    bus.req_read_size[i*AW +: AW] = 64'(rd_left[i]);
                end
                if (bus.req_write_enable[i] && wr_left[i] == 0) begin
                    bus.req_write_enable[i] = 1'b0;
                end else if (!bus.req_write_enable[i] && $urandom_range(0, 3) == 0) begin
                    bus.req_write_enable[i] = 1'b1;
                    wr_left[i] = $urandom_range(1, 4);
                    wr_next[i] = {$urandom, $urandom};
                    bus.req_write_size[i*AW +: AW] = 64'(wr_left[i]);
                end
                bus.req_read_addr[i*AW +: AW]  = rd_next[i];
                bus.req_write_addr[i*AW +: AW] = wr_next[i];
                bus.req_write_data[i*DW +: DW] = $urandom;
                bus.req_finish_read[i]  = (rd_owner == i) && bus.req_read_enable[i] && (bus.mem_read_ready == 64'd1);
                bus.req_finish_write[i] = (wr_owner == i) && bus.req_write_enable[i] && (bus.mem_write_ready == 64'd1);
            end
            e = '0;
            e.rd_grant = onehot(rd_owner);
            e.wr_grant = onehot(wr_owner);
            e.rd_ready = (bus.mem_read_ready == 64'd1) ? onehot(rd_owner) : '0;
            e.wr_ready = (bus.mem_write_ready == 64'd1) ? onehot(wr_owner) : '0;
            if (rd_owner >= 0) begin
                e.rd_en   = bus.req_read_enable[rd_owner];
                e.rd_fin  = bus.req_finish_read[rd_owner];
                e.rd_addr = bus.req_read_addr[rd_owner*AW +: AW];
                e.rd_size = bus.req_read_size[rd_owner*AW +: AW];
            end
            if (wr_owner >= 0) begin
                e.wr_en   = bus.req_write_enable[wr_owner];
                e.wr_fin  = bus.req_finish_write[wr_owner];
                e.wr_addr = bus.req_write_addr[wr_owner*AW +: AW];
                e.wr_size = bus.req_write_size[wr_owner*AW +: AW];
                e.wr_data = bus.req_write_data[wr_owner*DW +: DW];
            end
            e.rd_data  = bus.mem_read_data;
            e.rd_beats = rd_cnt;
            e.wr_beats = wr_cnt;
            exp_q.push_back(e);
        end
        @(negedge clk);
        #1;
        sb_on = 1'b0;
        check("sb_drain", 64'(exp_q.size()), 0);
        check("sb_min_cycles", 64'(sb_cycle >= N_RAND_CYCLES), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
